// File: rtl/regfile_mp.sv
// Multi-port register file with x0 hardwired to zero, write-through read bypass,
// and a per-register scoreboard of pending writes.
module regfile_mp #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 2,
    localparam int IDXW = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD*IDXW-1:0]  ra,
    output logic [NRD*XLEN-1:0]  rdata,
    output logic [NRD-1:0]       rbusy,
    input  logic [NWR-1:0]       we,
    input  logic [NWR*IDXW-1:0]  wa,
    input  logic [NWR*XLEN-1:0]  wd,
    input  logic                 iss_en,
    input  logic [IDXW-1:0]      iss_idx,
    output logic [NREG-1:0]      busy,
    output logic                 wr_conflict
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            wr_conflict_q;
    logic            wr_conflict_d;

    logic [NREG-1:0] wr_hit;
    logic [XLEN-1:0] wr_val [NREG];
    logic            conflict_now;

    // Later ports overwrite earlier ones, so the highest-numbered port wins.
    always_comb begin
        logic [IDXW-1:0] widx;
        wr_hit       = '0;
        conflict_now = 1'b0;
        widx         = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            wr_val[i] = '0;
        end
        for (int unsigned p = 0; p < NWR; p++) begin
            widx = wa[p*IDXW +: IDXW];
            if (we[p] && widx != '0) begin
                if (wr_hit[widx]) begin
                    conflict_now = 1'b1;
                end
                wr_hit[widx] = 1'b1;
                wr_val[widx] = wd[p*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NREG; i++) begin
            regs_d[i] = wr_hit[i] ? wr_val[i] : regs_q[i];
        end
        regs_d[0] = '0;
        busy_d    = busy_q & ~wr_hit;
        if (iss_en) begin
            busy_d[iss_idx] = 1'b1;
        end
        busy_d[0]     = 1'b0;
        wr_conflict_d = wr_conflict_q | conflict_now;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q        <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q        <= busy_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    // Reads are gated by reset so in-flight write data cannot bypass while held.
    always_comb begin
        logic [IDXW-1:0] ridx;
        rdata = '0;
        rbusy = '0;
        ridx  = '0;
        for (int unsigned p = 0; p < NRD; p++) begin
            ridx = ra[p*IDXW +: IDXW];
            if (rst && ridx != '0) begin
                rdata[p*XLEN +: XLEN] = wr_hit[ridx] ? wr_val[ridx] : regs_q[ridx];
                rbusy[p]              = busy_q[ridx] & ~wr_hit[ridx];
            end
        end
    end

    assign busy        = busy_q;
    assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two configurations run in turn, each checked against a
// behavioural register/scoreboard model plus directed literal expectations.
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Generic stimulus, sized for the widest configuration.
    logic        rst_n_g;
    logic [1:0]  we_g;
    logic [4:0]  wa_g [2];
    logic [31:0] wd_g [2];
    logic [4:0]  ra_g [3];
    logic        iss_en_g;
    logic [4:0]  iss_idx_g;

    // Configuration A: XLEN=32 NREG=32 NRD=2 NWR=2
    logic [9:0]  ra_a;
    logic [63:0] rdata_a;
    logic [1:0]  rbusy_a;
    logic [1:0]  we_a;
    logic [9:0]  wa_a;
    logic [63:0] wd_a;
    logic [31:0] busy_a;
    logic        wrc_a;

    // Configuration B: XLEN=8 NREG=16 NRD=3 NWR=1
    logic [11:0] ra_b;
    logic [23:0] rdata_b;
    logic [2:0]  rbusy_b;
    logic [0:0]  we_b;
    logic [3:0]  wa_b;
    logic [7:0]  wd_b;
    logic [3:0]  iss_idx_b;
    logic [15:0] busy_b;
    logic        wrc_b;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            ra_a[p*5 +: 5]  = ra_g[p];
            wa_a[p*5 +: 5]  = wa_g[p];
            wd_a[p*32 +: 32] = wd_g[p];
        end
        we_a = we_g;
        for (int p = 0; p < 3; p++) begin
            ra_b[p*4 +: 4] = ra_g[p][3:0];
        end
        we_b      = we_g[0:0];
        wa_b      = wa_g[0][3:0];
        wd_b      = wd_g[0][7:0];
        iss_idx_b = iss_idx_g[3:0];
    end

    regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2)) dut_a (
        .clk(clk), .rst(rst_n_g), .ra(ra_a), .rdata(rdata_a), .rbusy(rbusy_a),
        .we(we_a), .wa(wa_a), .wd(wd_a), .iss_en(iss_en_g), .iss_idx(iss_idx_g),
        .busy(busy_a), .wr_conflict(wrc_a)
    );

    regfile_mp #(.XLEN(8), .NREG(16), .NRD(3), .NWR(1)) dut_b (
        .clk(clk), .rst(rst_n_g), .ra(ra_b), .rdata(rdata_b), .rbusy(rbusy_b),
        .we(we_b), .wa(wa_b), .wd(wd_b), .iss_en(iss_en_g), .iss_idx(iss_idx_b),
        .busy(busy_b), .wr_conflict(wrc_b)
    );

    // Active configuration
    logic        sel;
    int          nreg, nrd, nwr;
    logic [31:0] xmask;
    logic [1:0]  wemask;
    logic        chk_on;

    logic [31:0] act_rdata [3];
    logic        act_rbusy [3];
    logic [31:0] act_busy;
    logic        act_conf;

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            act_rdata[p] = '0;
            act_rbusy[p] = 1'b0;
        end
        act_busy = '0;
        act_conf = 1'b0;
        if (!sel) begin
            for (int p = 0; p < 2; p++) begin
                act_rdata[p] = rdata_a[p*32 +: 32];
                act_rbusy[p] = rbusy_a[p];
            end
            act_busy = busy_a;
            act_conf = wrc_a;
        end else begin
            for (int p = 0; p < 3; p++) begin
                act_rdata[p] = {24'b0, rdata_b[p*8 +: 8]};
                act_rbusy[p] = rbusy_b[p];
            end
            act_busy = {16'b0, busy_b};
            act_conf = wrc_b;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cfg=%0d actual=%0h required=%0h t=%0t", nm, sel, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural register contents and pending-write set.
    logic [31:0] mreg [32];
    logic [31:0] mbusy;
    logic        mconf;

    function automatic logic written(input logic [4:0] a);
        for (int q = 0; q < nwr; q++)
            if (we_g[q] && wa_g[q] == a && a != 5'd0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] winner(input logic [4:0] a);
        logic [31:0] v = '0;
        for (int q = 0; q < nwr; q++)
            if (we_g[q] && wa_g[q] == a) v = wd_g[q];
        return v;
    endfunction

    function automatic logic [31:0] exp_rdata(input int p);
        logic [4:0] a = ra_g[p];
        if (!rst_n_g || a == 5'd0) return '0;
        return written(a) ? winner(a) : mreg[a];
    endfunction

    function automatic logic exp_rbusy(input int p);
        logic [4:0] a = ra_g[p];
        return rst_n_g && a != 5'd0 && mbusy[a] && !written(a);
    endfunction

    function automatic logic conflict_now();
        for (int q = 0; q < nwr; q++)
            for (int r = q + 1; r < nwr; r++)
                if (we_g[q] && we_g[r] && wa_g[q] == wa_g[r] && wa_g[q] != 5'd0) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n_g) begin
        if (!rst_n_g) begin
            for (int i = 0; i < 32; i++) mreg[i] <= '0;
            mbusy <= '0;
            mconf <= 1'b0;
        end else begin
            for (int q = 0; q < nwr; q++) begin
                if (we_g[q] && wa_g[q] != 5'd0) begin
                    mreg[wa_g[q]]  <= wd_g[q];
                    mbusy[wa_g[q]] <= 1'b0;
                end
            end
            if (iss_en_g && iss_idx_g != 5'd0) mbusy[iss_idx_g] <= 1'b1;
            if (conflict_now()) mconf <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int p = 0; p < nrd; p++) begin
                chk($sformatf("rdata%0d", p), act_rdata[p], exp_rdata(p));
                chk($sformatf("rbusy%0d", p), 32'(act_rbusy[p]), 32'(exp_rbusy(p)));
            end
            chk("busy", act_busy, mbusy);
            chk("wr_conflict", 32'(act_conf), 32'(mconf));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we_g      = '0;
        wa_g[0]   = '0;
        wa_g[1]   = '0;
        wd_g[0]   = '0;
        wd_g[1]   = '0;
        iss_en_g  = 1'b0;
        iss_idx_g = '0;
    endtask

    task automatic set_cfg(input logic b);
        sel    = b;
        nreg   = b ? 16 : 32;
        nrd    = b ? 3 : 2;
        nwr    = b ? 1 : 2;
        xmask  = b ? 32'h0000_00FF : 32'hFFFF_FFFF;
        wemask = b ? 2'b01 : 2'b11;
    endtask

    function automatic logic [4:0] rnd_idx();
        if ($urandom_range(0, 2) == 0) return 5'($urandom_range(0, 3));
        return 5'($urandom_range(0, nreg - 1));
    endfunction

    task automatic run_dir();
        rst_n_g = 1'b0;
        idle();
        for (int p = 0; p < 3; p++) ra_g[p] = '0;
        step();
        #1 chk("rst_busy", act_busy, 32'd0);
        step();
        rst_n_g = 1'b1;

        // Basic write with bypass, then hold
        we_g = 2'b01; wa_g[0] = 5'd5; wd_g[0] = 32'hDEADBEEF & xmask; ra_g[0] = 5'd5;
        #1 chk("wr_bypass", act_rdata[0], 32'hDEADBEEF & xmask);
        step(); idle();
        #1 chk("wr_hold", act_rdata[0], 32'hDEADBEEF & xmask);
        step();
        #1 chk("wr_hold2", act_rdata[0], 32'hDEADBEEF & xmask);

        // x0 writes and issues are discarded
        we_g = 2'b11 & wemask; wa_g[0] = 5'd0; wa_g[1] = 5'd0;
        wd_g[0] = 32'h1234 & xmask; wd_g[1] = 32'h1234 & xmask;
        iss_en_g = 1'b1; iss_idx_g = 5'd0; ra_g[0] = 5'd0;
        #1 chk("x0_bypass", act_rdata[0], 32'd0);
        step(); idle();
        #1 chk("x0_read", act_rdata[0], 32'd0);
        chk("x0_busy", act_busy, 32'd0);
        chk("x0_conf", 32'(act_conf), 32'd0);

        // Port priority and sticky conflict
        if (nwr > 1) begin
            we_g = 2'b11; wa_g[0] = 5'd7; wa_g[1] = 5'd7; wd_g[0] = 32'h11; wd_g[1] = 32'h22;
            ra_g[0] = 5'd7;
            #1 chk("prio_bypass", act_rdata[0], 32'h22);
            chk("conf_pre", 32'(act_conf), 32'd0);
            step(); idle();
            #1 chk("prio_hold", act_rdata[0], 32'h22);
            chk("conf_set", 32'(act_conf), 32'd1);
            step(); step();
            #1 chk("conf_sticky", 32'(act_conf), 32'd1);
        end

        // Scoreboard set, clear by write, set-wins on simultaneous
        iss_en_g = 1'b1; iss_idx_g = 5'd3; ra_g[0] = 5'd3;
        #1 chk("sb_pre", 32'(act_rbusy[0]), 32'd0);
        step(); idle();
        #1 chk("sb_busy3", 32'(act_busy[3]), 32'd1);
        chk("sb_rbusy", 32'(act_rbusy[0]), 32'd1);
        we_g = 2'b01; wa_g[0] = 5'd3; wd_g[0] = 32'h55 & xmask;
        #1 chk("sb_rbusy_wr", 32'(act_rbusy[0]), 32'd0);
        chk("sb_busy_still", 32'(act_busy[3]), 32'd1);
        step(); idle();
        #1 chk("sb_cleared", 32'(act_busy[3]), 32'd0);
        we_g = 2'b01; wa_g[0] = 5'd3; iss_en_g = 1'b1; iss_idx_g = 5'd3;
        step(); idle();
        #1 chk("sb_set_wins", 32'(act_busy[3]), 32'd1);

        // Fill, issue x9, then asynchronous reset mid-cycle
        for (int i = 1; i < nreg; i++) begin
            we_g = 2'b01; wa_g[0] = 5'(i); wd_g[0] = 32'(i);
            step();
        end
        idle();
        iss_en_g = 1'b1; iss_idx_g = 5'd9;
        step(); idle();
        ra_g[0] = 5'd9; ra_g[1] = 5'd1;
        #1 chk("fill_x9", act_rdata[0], 32'd9);
        chk("fill_x1", act_rdata[1], 32'd1);
        chk("fill_rbusy", 32'(act_rbusy[0]), 32'd1);
        chk("fill_busy", act_busy, 32'h0000_0200);
        chk("fill_conf", 32'(act_conf), (nwr > 1) ? 32'd1 : 32'd0);
        #1 rst_n_g = 1'b0;
        we_g = 2'b01; wa_g[0] = 5'd9; wd_g[0] = 32'h77 & xmask;
        #1 chk("arst_rd0", act_rdata[0], 32'd0);
        chk("arst_rd1", act_rdata[1], 32'd0);
        chk("arst_rbusy", 32'(act_rbusy[0]), 32'd0);
        chk("arst_busy", act_busy, 32'd0);
        chk("arst_conf", 32'(act_conf), 32'd0);
        step();
        #1 chk("arst_wr_ignored", act_rdata[0], 32'd0);
        idle();
        rst_n_g = 1'b1;
        #1 chk("post_rst_x9", act_rdata[0], 32'd0);
        step();
    endtask

    task automatic run_rand(input int n);
        for (int k = 0; k < n; k++) begin
            rst_n_g   = ($urandom_range(0, 99) != 0);
            we_g      = 2'($urandom) & wemask;
            wa_g[0]   = rnd_idx();
            wa_g[1]   = rnd_idx();
            wd_g[0]   = $urandom & xmask;
            wd_g[1]   = $urandom & xmask;
            iss_en_g  = ($urandom_range(0, 1) == 1);
            iss_idx_g = rnd_idx();
            for (int p = 0; p < 3; p++)
                ra_g[p] = ($urandom_range(0, 3) == 0) ? wa_g[$urandom_range(0, 1)] : rnd_idx();
            if (nreg == 16)
                for (int p = 0; p < 3; p++) ra_g[p] = ra_g[p] & 5'h0F;
            step();
        end
        rst_n_g = 1'b1;
        idle();
    endtask

    initial begin
        chk_on  = 1'b0;
        rst_n_g = 1'b0;
        idle();
        for (int p = 0; p < 3; p++) ra_g[p] = '0;
        set_cfg(1'b0);
        step();
        chk_on = 1'b1;
        run_dir();
        run_rand(1500);
        rst_n_g = 1'b0;
        set_cfg(1'b1);
        run_dir();
        run_rand(1500);
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
